// File: rtl/pc_trace_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : pc_trace_monitor
//  Purpose  : Captures program-counter changes into a circular trace buffer,
//             detects halts, and streams the trace out oldest-first.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_trace_monitor #(
    parameter int DEPTH    = 16,
    parameter int HALT_CNT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               in_PC,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     dump,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [3:0]               out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     halted,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               branch_cnt,
    output logic                     done
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_SW = $clog2(HALT_CNT);
    localparam logic [c_AW:0]   c_FULL       = (c_AW + 1)'(DEPTH);
    localparam logic [c_SW-1:0] c_STABLE_END = c_SW'(HALT_CNT - 2);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CAPTURE = 2'd1;
    localparam logic [1:0] c_HALTED  = 2'd2;
    localparam logic [1:0] c_DUMP    = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;

    logic [3:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_left;
    logic [c_AW:0]   r_count;
    logic [7:0]      r_branch;
    logic            r_ovf;
    logic            r_first;
    logic [c_SW-1:0] r_stable;
    logic [3:0]      r_last_pc;
    logic            r_out_valid;
    logic [3:0]      r_out_data;
    logic            r_out_last;
    logic            r_busy;
    logic            r_halted;
    logic            r_done;

    logic            w_capture;
    logic            w_pc_change;
    logic            w_write;
    logic            w_halt_hit;
    logic            w_accept;
    logic            w_start_cap;
    logic            w_dump_go;
    logic [3:0]      w_seq_pc;
    logic [c_AW-1:0] w_rd_first;

    assign w_capture   = (r_state == c_CAPTURE);
    assign w_pc_change = (in_PC != r_last_pc);
    assign w_seq_pc    = r_last_pc + 4'd1;
    assign w_write     = w_capture && (r_first || w_pc_change);
    assign w_halt_hit  = w_capture && !r_first && !w_pc_change && (r_stable == c_STABLE_END);
    assign w_accept    = r_out_valid && out_ready;
    assign w_start_cap = start && ((r_state == c_IDLE) || ((r_state == c_HALTED) && !dump));
    assign w_dump_go   = (r_state == c_HALTED) && dump;
    // Oldest entry: a full buffer wraps back to wr_ptr itself.
    assign w_rd_first  = r_wr_ptr - r_count[c_AW-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) w_state_nxt = c_CAPTURE;
            end
            c_CAPTURE: begin
                if (stop || w_halt_hit) w_state_nxt = c_HALTED;
            end
            c_HALTED: begin
                if (dump) begin
                    w_state_nxt = (r_count == '0) ? c_IDLE : c_DUMP;
                end else if (start) begin
                    w_state_nxt = c_CAPTURE;
                end
            end
            c_DUMP: begin
                if (w_accept && r_out_last) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst && w_write) begin
            r_mem[r_wr_ptr] <= in_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_left      <= '0;
            r_count     <= '0;
            r_branch    <= '0;
            r_ovf       <= 1'b0;
            r_first     <= 1'b0;
            r_stable    <= '0;
            r_last_pc   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_busy   <= (w_state_nxt == c_CAPTURE) || (w_state_nxt == c_DUMP);
            r_halted <= (w_state_nxt == c_HALTED);

            if (w_start_cap) begin
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_ovf    <= 1'b0;
                r_branch <= '0;
                r_stable <= '0;
                r_first  <= 1'b1;
            end

            if (w_write) begin
                r_wr_ptr  <= r_wr_ptr + c_AW'(1);
                r_last_pc <= in_PC;
                r_first   <= 1'b0;
                if (r_count == c_FULL) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_count <= r_count + (c_AW + 1)'(1);
                end
            end

            // Branch and stability tracking only once a reference PC exists.
            if (w_capture && !r_first) begin
                if (w_pc_change) begin
                    r_stable <= '0;
                    if ((in_PC != w_seq_pc) && (r_branch != 8'hFF)) begin
                        r_branch <= r_branch + 8'd1;
                    end
                end else begin
                    r_stable <= r_stable + c_SW'(1);
                end
            end

            if (w_dump_go) begin
                if (r_count == '0) begin
                    r_done <= 1'b1;
                end else begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_mem[w_rd_first];
                    r_out_last  <= (r_count == (c_AW + 1)'(1));
                    r_rd_ptr    <= w_rd_first + c_AW'(1);
                    r_left      <= r_count[c_AW-1:0] - c_AW'(1);
                end
            end

            if ((r_state == c_DUMP) && w_accept) begin
                if (r_out_last) begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_done      <= 1'b1;
                end else begin
                    r_out_data <= r_mem[r_rd_ptr];
                    r_rd_ptr   <= r_rd_ptr + c_AW'(1);
                    r_left     <= r_left - c_AW'(1);
                    r_out_last <= (r_left == c_AW'(1));
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign busy       = r_busy;
    assign halted     = r_halted;
    assign overflow   = r_ovf;
    assign count      = r_count;
    assign branch_cnt = r_branch;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pc_trace_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_trace_monitor
//  Purpose  : Self-checking bench for pc_trace_monitor (vectors, directed
//             corner sequences, randomized run against a queue-based model).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_trace_monitor;

    localparam int DEPTH    = 16;
    localparam int HALT_CNT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] in_PC = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dump = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_last;
    logic       busy;
    logic       halted;
    logic       overflow;
    logic [4:0] count;
    logic [7:0] branch_cnt;
    logic       done;

    pc_trace_monitor #(.DEPTH(DEPTH), .HALT_CNT(HALT_CNT)) dut (
        .clk(clk), .rst(rst), .in_PC(in_PC), .start(start), .stop(stop),
        .dump(dump), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .busy(busy), .halted(halted),
        .overflow(overflow), .count(count), .branch_cnt(branch_cnt), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: trace as a queue of retained PCs, dump as a copy of it.
    int         m_mode;   // 0 idle, 1 capture, 2 halted, 3 dump
    logic [3:0] m_trace[$];
    logic [3:0] m_dq[$];
    bit         m_ovf;
    int         m_br;
    bit         m_first;
    logic [3:0] m_last;
    int         m_same;
    bit         m_done;

    function automatic void m_push(input logic [3:0] v);
        m_trace.push_back(v);
        if (m_trace.size() > DEPTH) begin
            void'(m_trace.pop_front());
            m_ovf = 1'b1;
        end
    endfunction

    function automatic void m_begin();
        m_trace.delete();
        m_ovf = 1'b0; m_br = 0; m_first = 1'b1; m_same = 0;
        m_mode = 1;
    endfunction

    function automatic void model_edge(input bit rn, s, p, d, rdy, input logic [3:0] pc);
        m_done = 1'b0;
        if (!rn) begin
            m_mode = 0; m_trace.delete(); m_dq.delete();
            m_ovf = 1'b0; m_br = 0; m_first = 1'b0; m_same = 0;
            return;
        end
        case (m_mode)
            0: if (s) m_begin();
            1: begin
                if (m_first) begin
                    m_push(pc); m_first = 1'b0; m_last = pc;
                end else if (pc != m_last) begin
                    if (int'(pc) != (int'(m_last) + 1) % 16 && m_br < 255) m_br++;
                    m_push(pc); m_last = pc; m_same = 0;
                end else begin
                    m_same++;
                end
                if (p || m_same == HALT_CNT - 1) m_mode = 2;
            end
            2: begin
                if (d) begin
                    if (m_trace.size() == 0) begin
                        m_done = 1'b1; m_mode = 0;
                    end else begin
                        m_dq = m_trace; m_mode = 3;
                    end
                end else if (s) begin
                    m_begin();
                end
            end
            default: begin
                if (rdy) begin
                    void'(m_dq.pop_front());
                    if (m_dq.size() == 0) begin
                        m_mode = 0; m_done = 1'b1;
                    end
                end
            end
        endcase
    endfunction

    task automatic cmp_model();
        chk("m_valid", out_valid, int'(m_mode == 3));
        if (m_mode == 3) begin
            chk("m_data", out_data, m_dq[0]);
            chk("m_last", out_last, int'(m_dq.size() == 1));
        end else begin
            chk("m_last", out_last, 0);
        end
        chk("m_busy", busy, int'(m_mode == 1 || m_mode == 3));
        chk("m_halted", halted, int'(m_mode == 2));
        chk("m_overflow", overflow, m_ovf);
        chk("m_count", count, m_trace.size());
        chk("m_branch", branch_cnt, m_br);
        chk("m_done", done, m_done);
    endtask

    task automatic step(input bit rn, s, p, d, rdy, input logic [3:0] pc);
        rst = rn; start = s; stop = p; dump = d; out_ready = rdy; in_PC = pc;
        @(posedge clk);
        model_edge(rn, s, p, d, rdy, pc);
        #1;
        cmp_model();
    endtask

    task automatic cyc(input logic [3:0] pc);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pc);
    endtask

    typedef struct {
        bit s, p, d, rdy;
        int pc;
        bit e_busy, e_halted, e_valid, e_last, e_done, e_ovf;
        int e_data, e_cnt, e_br;
    } vec_t;
    vec_t tq[$];

    function automatic void addv(input bit s, p, d, rdy, input int pc,
                                 input bit eb, eh, ev, el, ed, eo,
                                 input int edata, ecnt, ebr);
        vec_t v;
        v.s = s; v.p = p; v.d = d; v.rdy = rdy; v.pc = pc;
        v.e_busy = eb; v.e_halted = eh; v.e_valid = ev; v.e_last = el;
        v.e_done = ed; v.e_ovf = eo; v.e_data = edata; v.e_cnt = ecnt; v.e_br = ebr;
        tq.push_back(v);
    endfunction

    logic [3:0] expd[6];
    bit         rp[6];
    logic [3:0] pc_r;

    initial begin
        // start; 0,1,2,3,3,3,3 halts; then dump the four entries
        //   s p d r pc   busy hlt vld lst dn ov data cnt br
        addv(1,0,0,0,0,   1,0,0,0,0,0, 0,0,0);
        addv(0,0,0,0,0,   1,0,0,0,0,0, 0,1,0);
        addv(0,0,0,0,1,   1,0,0,0,0,0, 0,2,0);
        addv(0,0,0,0,2,   1,0,0,0,0,0, 0,3,0);
        addv(0,0,0,0,3,   1,0,0,0,0,0, 0,4,0);
        addv(0,0,0,0,3,   1,0,0,0,0,0, 0,4,0);
        addv(0,0,0,0,3,   1,0,0,0,0,0, 0,4,0);
        addv(0,0,0,0,3,   0,1,0,0,0,0, 0,4,0);
        addv(0,0,0,0,9,   0,1,0,0,0,0, 0,4,0);
        addv(0,0,1,0,9,   1,0,1,0,0,0, 0,4,0);
        addv(0,0,0,1,9,   1,0,1,0,0,0, 1,4,0);
        addv(0,0,0,1,9,   1,0,1,0,0,0, 2,4,0);
        addv(0,0,0,1,9,   1,0,1,1,0,0, 3,4,0);
        addv(0,0,0,1,9,   0,0,0,0,1,0, 0,4,0);
        addv(0,0,0,0,9,   0,0,0,0,0,0, 0,4,0);

        step(1'b0, 0, 0, 0, 0, 4'd0);
        step(1'b0, 0, 0, 0, 0, 4'd0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);

        foreach (tq[i]) begin
            step(1'b1, tq[i].s, tq[i].p, tq[i].d, tq[i].rdy, 4'(tq[i].pc));
            chk($sformatf("tv%0d_busy", i), busy, tq[i].e_busy);
            chk($sformatf("tv%0d_halted", i), halted, tq[i].e_halted);
            chk($sformatf("tv%0d_valid", i), out_valid, tq[i].e_valid);
            chk($sformatf("tv%0d_last", i), out_last, tq[i].e_last);
            chk($sformatf("tv%0d_done", i), done, tq[i].e_done);
            chk($sformatf("tv%0d_ovf", i), overflow, tq[i].e_ovf);
            chk($sformatf("tv%0d_count", i), count, tq[i].e_cnt);
            chk($sformatf("tv%0d_branch", i), branch_cnt, tq[i].e_br);
            if (tq[i].e_valid) chk($sformatf("tv%0d_data", i), out_data, tq[i].e_data);
        end

        // Branch counting, with a start mid-capture that must be ignored
        step(1, 1, 0, 0, 0, 4'd0);
        cyc(4'd0); cyc(4'd1);
        step(1, 1, 0, 0, 0, 4'd5);
        cyc(4'd6); cyc(4'd2);
        step(1, 0, 1, 0, 0, 4'd2);
        chk("br_branch", branch_cnt, 2);
        chk("br_count", count, 5);
        chk("br_halted", halted, 1);
        // 15 -> 0 is sequential; stop coinciding with a write keeps the write
        step(1, 1, 0, 0, 0, 4'd14);
        cyc(4'd14); cyc(4'd15); cyc(4'd0);
        step(1, 0, 1, 0, 0, 4'd1);
        chk("wrap_branch", branch_cnt, 0);
        chk("wrap_count", count, 4);

        // Overflow: 18 writes, oldest 16 retained are 2..15,0,1
        step(1, 1, 0, 0, 0, 4'd0);
        for (int i = 0; i < 16; i++) cyc(4'(i));
        cyc(4'd0); cyc(4'd1);
        step(1, 0, 1, 0, 0, 4'd1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 16);
        step(1, 0, 0, 1, 0, 4'd1);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_valid", out_valid, 1);
            chk("ovf_data", out_data, (i + 2) % 16);
            chk("ovf_last", out_last, int'(i == 15));
            step(1, 0, 0, 0, 1, 4'd1);
        end
        chk("ovf_done", done, 1);
        chk("ovf_valid_end", out_valid, 0);
        cyc(4'd1);
        chk("ovf_done_pulse", done, 0);

        // Back-pressure: out_ready 1,0,0,1,1,1
        step(1, 1, 0, 0, 0, 4'd7);
        cyc(4'd7); cyc(4'd8); cyc(4'd9); cyc(4'd10);
        step(1, 0, 1, 0, 0, 4'd10);
        step(1, 0, 0, 1, 0, 4'd10);
        expd[0] = 4'd7; expd[1] = 4'd8; expd[2] = 4'd8;
        expd[3] = 4'd8; expd[4] = 4'd9; expd[5] = 4'd10;
        rp[0] = 1; rp[1] = 0; rp[2] = 0; rp[3] = 1; rp[4] = 1; rp[5] = 1;
        for (int k = 0; k < 6; k++) begin
            chk("bp_data", out_data, expd[k]);
            chk("bp_last", out_last, int'(k == 5));
            step(1, 0, 0, 0, rp[k], 4'd10);
        end
        chk("bp_done", done, 1);

        // Reset mid-dump, then a one-entry capture stopped on its first cycle
        step(1, 1, 0, 0, 0, 4'd1);
        for (int i = 1; i <= 5; i++) cyc(4'(i));
        step(1, 0, 1, 0, 0, 4'd5);
        step(1, 0, 0, 1, 0, 4'd5);
        step(1, 0, 0, 0, 1, 4'd5);
        step(1, 0, 0, 0, 1, 4'd5);
        chk("mid_data", out_data, 3);
        step(0, 0, 0, 0, 1, 4'd5);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_data", out_data, 0);
        chk("mrst_last", out_last, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_halted", halted, 0);
        chk("mrst_count", count, 0);
        chk("mrst_done", done, 0);
        step(1, 1, 0, 0, 0, 4'd0);
        step(1, 0, 1, 0, 0, 4'd3);
        chk("one_count", count, 1);
        chk("one_halted", halted, 1);
        step(1, 0, 0, 1, 0, 4'd3);
        chk("one_valid", out_valid, 1);
        chk("one_data", out_data, 3);
        chk("one_last", out_last, 1);
        step(1, 0, 0, 0, 1, 4'd3);
        chk("one_done", done, 1);
        chk("one_valid_end", out_valid, 0);

        // Randomized run against the model
        pc_r = 4'd0;
        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(0, 7))
                0, 1, 2, 3: pc_r = pc_r + 4'd1;
                4, 5:       pc_r = pc_r;
                6:          pc_r = 4'($urandom);
                default:    pc_r = pc_r + 4'd3;
            endcase
            step(bit'($urandom_range(0, 299) != 0),
                 bit'($urandom_range(0, 99) < 6),
                 bit'($urandom_range(0, 99) < 4),
                 bit'($urandom_range(0, 99) < 15),
                 bit'($urandom_range(0, 99) < 70),
                 pc_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
